cfg_reg_bank: RTL and testbench

CFG_REG_BANK -- requirements
Module: cfg_reg_bank

---
 rtl/cfg_addr_decode.sv | 32 +++
 rtl/cfg_reg_bank.sv | 151 +++++++++++++++
 tb/tb_cfg_reg_bank.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_addr_decode.sv
// Address decoder for the config register bank.
// Converts a byte address into a register index and reports whether the
// address falls inside the bank.
//   addr_i  : byte address
//   index_o : register index, meaningful only while hit_o is high
//   hit_o   : address is >= BASE_ADDR and the index is below NUM_REGS
module cfg_addr_decode #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           STRB_WIDTH = 4,
  parameter int unsigned           NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  localparam int unsigned          IDX_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [IDX_WIDTH-1:0]  index_o,
  output logic                  hit_o
);

  localparam int unsigned           OFFS_SHIFT = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
  localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);

  logic [ADDR_WIDTH-1:0] word_idx;

  always_comb begin
    // Byte-offset bits within a word are dropped by the shift.
    word_idx = (addr_i - BASE_ADDR) >> OFFS_SHIFT;
    // The >= test rejects addresses that wrapped around below BASE_ADDR.
    hit_o    = (addr_i >= BASE_ADDR) && (word_idx < NUM_REGS_A);
    index_o  = word_idx[IDX_WIDTH-1:0];
  end

endmodule

// File: rtl/cfg_reg_bank.sv
// Configuration register bank with RW, read-only status and self-clearing
// command registers.
//   clk, rst        : clock and synchronous active-high reset
//   wr/waddr/wdata/wstrb : one-cycle byte-strobed write port
//   rd/raddr        : read request; rdata/rvalid answer one cycle later
//   status_in       : live values for read-only registers
//   reg_out         : register contents (RO slices show status_in)
//   reg_wr_pulse    : one-cycle pulse per accepted RW/PULSE write
//   wr_err/rd_err   : one-cycle out-of-range access pulses
//   err_count       : saturating count of error pulses
module cfg_reg_bank #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned           NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]   PULSE_MASK = '0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int unsigned          IDX_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [STRB_WIDTH-1:0]          wstrb,
  input  logic                           rd,
  input  logic [ADDR_WIDTH-1:0]          raddr,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           rvalid,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  output logic                           wr_err,
  output logic                           rd_err,
  output logic [15:0]                    err_count
);

  logic [IDX_WIDTH-1:0]  widx, ridx;
  logic                  whit, rhit;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] status_arr [NUM_REGS];
  logic [NUM_REGS-1:0]   pulse_q, pulse_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q;
  logic                  wr_err_q, rd_err_q;
  logic [15:0]           err_count_q, err_count_d;
  logic [16:0]           err_sum;

  cfg_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_wdec (
    .addr_i  (waddr),
    .index_o (widx),
    .hit_o   (whit)
  );

  cfg_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_rdec (
    .addr_i  (raddr),
    .index_o (ridx),
    .hit_o   (rhit)
  );

  // Write next-state. PULSE registers fall back to 0 every cycle, so a
  // write leaves only the strobed bytes for a single cycle. RO storage is
  // unused and held at 0.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i]  = (PULSE_MASK[i] || RO_MASK[i]) ? '0 : regs_q[i];
      pulse_d[i] = 1'b0;
      if (wr && whit && (widx == IDX_WIDTH'(i)) && !RO_MASK[i]) begin
        pulse_d[i] = 1'b1;
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (wstrb[b]) regs_d[i][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      status_arr[i] = status_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Read mux uses regs_q, so a same-cycle write is not yet visible.
  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      rdata_d = '0;
      if (rhit) begin
        if (RO_MASK[ridx])           rdata_d = status_arr[ridx];
        else if (!PULSE_MASK[ridx])  rdata_d = regs_q[ridx];
      end
    end
  end

  always_comb begin
    err_sum     = {1'b0, err_count_q} + 17'(wr_err_q) + 17'(rd_err_q);
    err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (PULSE_MASK[i] || RO_MASK[i]) ? '0 : INIT_VALUE;
      end
      pulse_q     <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      rd_err_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pulse_q     <= pulse_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rd;
      wr_err_q    <= wr && !whit;
      rd_err_q    <= rd && !rhit;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? status_arr[i] : regs_q[i];
    end
  end

  assign rdata        = rdata_q;
  assign rvalid       = rvalid_q;
  assign reg_wr_pulse = pulse_q;
  assign wr_err       = wr_err_q;
  assign rd_err       = rd_err_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Self-checking bench for cfg_reg_bank: read responses go through an
// expectation queue drained by a monitor; write-side effects are checked
// inline after each clock edge.
module tb_cfg_reg_bank;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned NR = 16;
  localparam logic [DW-1:0] INIT   = 32'hC0DE_0001;
  localparam logic [NR-1:0] ROM    = 16'h0008;
  localparam logic [NR-1:0] PULSEM = 16'h0002;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr, rd;
  logic [AW-1:0]     waddr, raddr;
  logic [DW-1:0]     wdata;
  logic [SW-1:0]     wstrb;
  logic [DW-1:0]     rdata;
  logic              rvalid;
  logic [NR*DW-1:0]  status_in;
  logic [NR*DW-1:0]  reg_out;
  logic [NR-1:0]     reg_wr_pulse;
  logic              wr_err, rd_err;
  logic [15:0]       err_count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  rd_exp_t mon_e;

  cfg_reg_bank #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .STRB_WIDTH (SW),
    .NUM_REGS   (NR),
    .BASE_ADDR  (32'h0),
    .RO_MASK    (ROM),
    .PULSE_MASK (PULSEM),
    .INIT_VALUE (INIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr),
    .waddr        (waddr),
    .wdata        (wdata),
    .wstrb        (wstrb),
    .rd           (rd),
    .raddr        (raddr),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .status_in    (status_in),
    .reg_out      (reg_out),
    .reg_wr_pulse (reg_wr_pulse),
    .wr_err       (wr_err),
    .rd_err       (rd_err),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_unexpected: got rvalid=1 rdata=%0h expected no response", rdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("rdata", 64'(rdata), 64'(mon_e.data));
        check("rd_err", 64'(rd_err), 64'(mon_e.err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr    = 1'b0;
    rd    = 1'b0;
    wstrb = '0;
  endtask

  task automatic issue_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    wr    = 1'b1;
    waddr = a;
    wdata = d;
    wstrb = s;
  endtask

  task automatic issue_rd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e_err);
    rd    = 1'b1;
    raddr = a;
    exp_q.push_back(rd_exp_t'{data: d, err: e_err});
  endtask

  initial begin
    logic [DW-1:0] exp_v;
    status_in = '0;
    status_in[3*DW +: DW] = 32'hDEAD_BEEF;

    // Reset with wr and rd held high: both must be ignored.
    rst = 1'b1;
    issue_wr(32'h08, 32'hFFFF_FFFF, 4'hF);
    rd    = 1'b1;
    raddr = 32'h00;
    step();
    step();
    step();
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_wr_err", 64'(wr_err), 64'(0));
    check("rst_rd_err", 64'(rd_err), 64'(0));
    check("rst_pulse", 64'(reg_wr_pulse), 64'(0));
    check("rst_err_count", 64'(err_count), 64'(0));
    check("rst_reg2", 64'(reg_out[2*DW +: DW]), 64'(INIT));
    check("rst_reg1_pulse", 64'(reg_out[1*DW +: DW]), 64'(0));
    idle();
    rst = 1'b0;
    step();

    // Back-to-back reads over the whole bank.
    for (int i = 0; i < 16; i++) begin
      if (i == 1)      exp_v = 32'h0;
      else if (i == 3) exp_v = 32'hDEAD_BEEF;
      else             exp_v = INIT;
      issue_rd(AW'(i * 4), exp_v, 1'b0);
      step();
    end
    idle();
    step();
    step();
    check("scan_err_count", 64'(err_count), 64'(0));
    check("rdata_hold", 64'(rdata), 64'(INIT));

    // Byte-strobed write on a cleared register.
    issue_wr(32'h08, 32'h0, 4'hF);
    step();
    idle();
    step();
    issue_wr(32'h08, 32'hA5A5_A5A5, 4'b0101);
    step();
    check("strb_reg2", 64'(reg_out[2*DW +: DW]), 64'(32'h00A5_00A5));
    check("strb_pulse", 64'(reg_wr_pulse), 64'(16'h0004));
    idle();
    step();
    check("strb_pulse_off", 64'(reg_wr_pulse), 64'(0));
    check("strb_reg2_hold", 64'(reg_out[2*DW +: DW]), 64'(32'h00A5_00A5));

    // Self-clearing command register.
    issue_wr(32'h04, 32'h0000_0001, 4'hF);
    step();
    check("cmd_reg1_set", 64'(reg_out[1*DW +: DW]), 64'(1));
    check("cmd_pulse", 64'(reg_wr_pulse), 64'(16'h0002));
    idle();
    step();
    check("cmd_reg1_clr", 64'(reg_out[1*DW +: DW]), 64'(0));
    issue_rd(32'h04, 32'h0, 1'b0);
    step();
    idle();
    step();

    // Writes to the status register are dropped silently.
    issue_wr(32'h0C, 32'h1234_5678, 4'hF);
    step();
    check("ro_pulse", 64'(reg_wr_pulse), 64'(0));
    check("ro_wr_err", 64'(wr_err), 64'(0));
    idle();
    issue_rd(32'h0C, 32'hDEAD_BEEF, 1'b0);
    step();
    idle();
    step();

    // Zero strobe still pulses but changes nothing.
    issue_wr(32'h14, 32'hFFFF_FFFF, 4'h0);
    step();
    check("zstrb_pulse", 64'(reg_wr_pulse), 64'(16'h0020));
    check("zstrb_reg5", 64'(reg_out[5*DW +: DW]), 64'(INIT));
    idle();

    // Low offset bits ignored; last register in range.
    issue_wr(32'h1B, 32'h600D_600D, 4'hF);
    step();
    check("offs_reg6", 64'(reg_out[6*DW +: DW]), 64'(32'h600D_600D));
    issue_wr(32'h3F, 32'hFACE_0015, 4'hF);
    step();
    check("last_reg15", 64'(reg_out[15*DW +: DW]), 64'(32'hFACE_0015));
    check("last_pulse", 64'(reg_wr_pulse), 64'(16'h8000));
    idle();
    issue_rd(32'h3C, 32'hFACE_0015, 1'b0);
    step();
    idle();
    step();
    check("pre_miss_err_count", 64'(err_count), 64'(0));

    // Simultaneous write and read misses.
    issue_wr(32'h40, 32'hFFFF_FFFF, 4'hF);
    issue_rd(32'h44, 32'h0, 1'b1);
    step();
    check("miss_wr_err", 64'(wr_err), 64'(1));
    check("miss_rd_err", 64'(rd_err), 64'(1));
    check("miss_pulse", 64'(reg_wr_pulse), 64'(0));
    idle();
    step();
    check("miss_err_count", 64'(err_count), 64'(2));
    check("miss_wr_err_off", 64'(wr_err), 64'(0));
    check("miss_reg0", 64'(reg_out[0*DW +: DW]), 64'(INIT));

    // Drive the counter to 0xFFFE, then into saturation.
    for (int k = 0; k < 32766; k++) begin
      issue_wr(32'h40, 32'h0, 4'hF);
      issue_rd(32'h44, 32'h0, 1'b1);
      step();
    end
    idle();
    step();
    step();
    check("err_count_fffe", 64'(err_count), 64'(16'hFFFE));
    issue_wr(32'h40, 32'h0, 4'hF);
    issue_rd(32'h44, 32'h0, 1'b1);
    step();
    idle();
    step();
    check("err_count_sat", 64'(err_count), 64'(16'hFFFF));
    issue_wr(32'h80, 32'h0, 4'hF);
    step();
    idle();
    step();
    step();
    check("err_count_sat_hold", 64'(err_count), 64'(16'hFFFF));

    // Same-cycle read and write return the old value.
    issue_wr(32'h00, 32'h22, 4'hF);
    step();
    idle();
    step();
    issue_wr(32'h00, 32'h11, 4'hF);
    issue_rd(32'h00, 32'h22, 1'b0);
    step();
    idle();
    issue_rd(32'h00, 32'h11, 1'b0);
    step();
    idle();
    step();
    step();
    step();

    check("rd_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
